// File: rtl/alu_pkg.sv
// Shared types and helpers for the serial word assembler and the ALU operand path.
// Holds the FSM state encoding and the bit-counter width function.
package alu_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Bits needed to count 0..width, matching $clog2(width+1).
  function automatic int count_width(input int width);
    int w;
    w = 1;
    while ((1 << w) < (width + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/ser_word_assembler_if.sv
// Bit-in / word-out bundle between the flip-flop stage, the assembler and the ALU
// operand register.
interface ser_word_assembler_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) ();
  localparam int CW = count_width(WIDTH);

  // Handshake: a word transfers on any rising edge where word_valid and word_ready
  // are both 1; word_out stays stable while word_valid=1 and not taken. bit_valid
  // has no ready: a bit presented while a word is held and not taken is dropped.
  logic             bit_in;
  logic             bit_valid;
  logic             word_ready;
  logic             clr_overrun;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             overrun;
  logic [CW-1:0]    bit_count;

  modport master (
    output bit_in, bit_valid, word_ready, clr_overrun,
    input  word_out, word_valid, overrun, bit_count
  );

  modport slave (
    input  bit_in, bit_valid, word_ready, clr_overrun,
    output word_out, word_valid, overrun, bit_count
  );

endinterface

// File: rtl/bit_slot_counter.sv
// Modulo-WIDTH slot counter: selects the next bit position and flags the
// increment that completes a word.
module bit_slot_counter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = count_width(WIDTH)
) (
  input  logic          eclk,
  input  logic          rst,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_wrap
);

  logic [CW-1:0] r_count;

  assign o_count = r_count;
  assign o_wrap  = i_en && (r_count == CW'(WIDTH - 1));

  always_ff @(posedge eclk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_en) begin
      if (o_wrap) r_count <= '0;
      else        r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/ser_word_assembler.sv
// Serial-to-parallel word assembler feeding the ALU operand register: collects
// WIDTH accepted bits, then holds the word on a valid/ready handshake.
module ser_word_assembler
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 eclk,
  input  logic                 rst,
  ser_word_assembler_if.slave  bus,
  output logic [0:0]           o_dbg_state
);

  localparam int CW = count_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_word;
  logic             r_overrun;

  logic             w_hold;
  logic             w_take;
  logic             w_accept;
  logic             w_drop;
  logic             w_wrap;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_idx;
  logic [WIDTH-1:0] w_fill;

  assign w_hold   = (r_state == HOLD);
  assign w_take   = w_hold && bus.word_ready;
  assign w_accept = bus.bit_valid && (!w_hold || bus.word_ready);
  assign w_drop   = w_hold && !bus.word_ready && bus.bit_valid;

  // The shift register is cleared at each completion, so every slot is written
  // exactly once per word and OR-ing the new bit in is sufficient.
  assign w_idx  = LSB_FIRST ? w_count : (CW'(WIDTH - 1) - w_count);
  assign w_fill = r_shift | (WIDTH'(bus.bit_in) << w_idx);

  bit_slot_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_slot (
    .eclk    (eclk),
    .rst     (rst),
    .i_en    (w_accept),
    .o_count (w_count),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge eclk or negedge rst) begin
    if (!rst) begin
      r_state   <= FILL;
      r_shift   <= '0;
      r_word    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_word  <= w_fill;
        r_shift <= '0;
      end else if (w_accept) begin
        r_shift <= w_fill;
      end

      // Completion wins over take so a take-and-complete edge keeps the word valid.
      if (w_wrap)      r_state <= HOLD;
      else if (w_take) r_state <= FILL;

      if (w_drop)               r_overrun <= 1'b1;
      else if (bus.clr_overrun) r_overrun <= 1'b0;
    end
  end

  assign bus.word_out   = r_word;
  assign bus.word_valid = w_hold;
  assign bus.overrun    = r_overrun;
  assign bus.bit_count  = w_count;
  assign o_dbg_state    = r_state;

endmodule
